// File: rtl/flex_counter_ud_if.sv
// Signal bundle for flex_counter_ud: control inputs plus registered count/status.
// wrap_count is present only when FLEX_COUNTER_ROLLOVER_CNT_EN is defined.
interface flex_counter_ud_if #(
  parameter int NUM_CNT_BITS = 4
`ifdef FLEX_COUNTER_ROLLOVER_CNT_EN
  , parameter int WRAP_CNT_BITS = 8
`endif
);
  logic                    clear;
  logic                    count_enable;
  logic                    count_dir;
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic [NUM_CNT_BITS-1:0] rollover_val;
  logic                    sat_mode;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    rollover_flag;
  logic                    underflow_flag;
  logic                    at_zero;
`ifdef FLEX_COUNTER_ROLLOVER_CNT_EN
  logic [WRAP_CNT_BITS-1:0] wrap_count;
`endif

  modport master (
    output clear, count_enable, count_dir, load, load_val, rollover_val, sat_mode,
    input  count_out, rollover_flag, underflow_flag, at_zero
`ifdef FLEX_COUNTER_ROLLOVER_CNT_EN
    , input wrap_count
`endif
  );

  modport slave (
    input  clear, count_enable, count_dir, load, load_val, rollover_val, sat_mode,
    output count_out, rollover_flag, underflow_flag, at_zero
`ifdef FLEX_COUNTER_ROLLOVER_CNT_EN
    , output wrap_count
`endif
  );
endinterface

// File: rtl/flex_counter_ud.sv
// Up/down flex counter with load, wrap/saturate limits, underflow pulse and zero detect.
// Optional wrap-event counter output enabled by defining FLEX_COUNTER_ROLLOVER_CNT_EN.
module flex_counter_ud #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int WRAP_CNT_BITS = 8
) (
  input logic               CLK,
  input logic               nRST,
  flex_counter_ud_if.slave  bus
);

  typedef logic [NUM_CNT_BITS-1:0] cnt_t;

  localparam cnt_t CNT_ZERO = {NUM_CNT_BITS{1'b0}};
  localparam cnt_t CNT_ONE  = cnt_t'(1'b1);

  if (NUM_CNT_BITS < 1 || WRAP_CNT_BITS < 1) begin : g_param_check
    $error("flex_counter_ud: counter widths must be at least 1");
  end

  // Next value for an up step with a non-zero terminal value
  function automatic cnt_t up_next(input cnt_t cur, input cnt_t term, input logic sat);
    cnt_t res;
    if (cur < term) begin
      res = cur + CNT_ONE;
    end else if (sat) begin
      res = term;
    end else begin
      res = CNT_ONE;
    end
    return res;
  endfunction

  // Next value for a down step with a non-zero terminal value
  function automatic cnt_t down_next(input cnt_t cur, input cnt_t term, input logic sat);
    cnt_t res;
    if (cur == CNT_ZERO) begin
      res = sat ? CNT_ZERO : term;
    end else if (cur <= term) begin
      res = cur - CNT_ONE;
    end else begin
      res = term;
    end
    return res;
  endfunction

  cnt_t count_r;
  logic rollover_r;
  logic underflow_r;
  logic at_zero_r;

  cnt_t count_next_s;
  logic underflow_next_s;
  logic wrap_event_s;
  logic term_zero_s;

  assign term_zero_s = (bus.rollover_val == CNT_ZERO);

  // Next-state selection: clear > load > count step > hold
  always_comb begin
    count_next_s     = count_r;
    underflow_next_s = 1'b0;
    wrap_event_s     = 1'b0;
    if (bus.clear) begin
      count_next_s = CNT_ZERO;
    end else if (bus.load) begin
      count_next_s = bus.load_val;
    end else if (bus.count_enable && !term_zero_s) begin
      if (bus.count_dir) begin
        count_next_s = up_next(count_r, bus.rollover_val, bus.sat_mode);
        wrap_event_s = (count_r >= bus.rollover_val) && !bus.sat_mode;
      end else begin
        count_next_s     = down_next(count_r, bus.rollover_val, bus.sat_mode);
        underflow_next_s = (count_r == CNT_ZERO);
        wrap_event_s     = (count_r == CNT_ZERO) && !bus.sat_mode;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Count and status registers; flags derive from the value being registered
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_r     <= CNT_ZERO;
      rollover_r  <= 1'b0;
      underflow_r <= 1'b0;
      at_zero_r   <= 1'b1;
    end else begin
      count_r     <= count_next_s;
      rollover_r  <= (count_next_s == bus.rollover_val) && !term_zero_s;
      underflow_r <= underflow_next_s;
      at_zero_r   <= (count_next_s == CNT_ZERO);
    end
  end

  assign bus.count_out      = count_r;
  assign bus.rollover_flag  = rollover_r;
  assign bus.underflow_flag = underflow_r;
  assign bus.at_zero        = at_zero_r;

`ifdef FLEX_COUNTER_ROLLOVER_CNT_EN
  logic [WRAP_CNT_BITS-1:0] wrap_cnt_r;

  // Wrap-event counter: saturates at all-ones, cleared by clear, ignores load
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wrap_cnt_r <= {WRAP_CNT_BITS{1'b0}};
    end else if (bus.clear) begin
      wrap_cnt_r <= {WRAP_CNT_BITS{1'b0}};
    end else if (!bus.load && wrap_event_s && (wrap_cnt_r != {WRAP_CNT_BITS{1'b1}})) begin
      wrap_cnt_r <= wrap_cnt_r + {{(WRAP_CNT_BITS-1){1'b0}}, 1'b1};
    end else begin
      wrap_cnt_r <= wrap_cnt_r;
    end
  end

  assign bus.wrap_count = wrap_cnt_r;
`else
  logic unused_wrap_s;
  assign unused_wrap_s = wrap_event_s;
`endif

endmodule

// File: tb/tb_flex_counter_ud.sv
// Directed self-checking bench for flex_counter_ud; checks are immediate assertions.
module tb_flex_counter_ud;
  logic CLK;
  logic nRST;
  int   pass_cnt;
  int   total_cnt;

`ifdef FLEX_COUNTER_ROLLOVER_CNT_EN
  flex_counter_ud_if #(.NUM_CNT_BITS(4), .WRAP_CNT_BITS(8)) bus ();
`else
  flex_counter_ud_if #(.NUM_CNT_BITS(4)) bus ();
`endif

  flex_counter_ud #(.NUM_CNT_BITS(4), .WRAP_CNT_BITS(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag, input int cnt, input int roll, input int und, input int zero);
    check({tag, ".count"}, 32'(bus.count_out), 32'(cnt));
    check({tag, ".roll"},  32'(bus.rollover_flag), 32'(roll));
    check({tag, ".under"}, 32'(bus.underflow_flag), 32'(und));
    check({tag, ".zero"},  32'(bus.at_zero), 32'(zero));
  endtask

  initial begin
    int exp_cnt;
    pass_cnt  = 0;
    total_cnt = 0;
    nRST = 1'b0;
    bus.clear = 1'b0; bus.count_enable = 1'b0; bus.count_dir = 1'b1; bus.load = 1'b0;
    bus.load_val = 4'd0; bus.rollover_val = 4'd0; bus.sat_mode = 1'b0;
    #12;
    check_all("reset", 0, 0, 0, 1);
`ifdef FLEX_COUNTER_ROLLOVER_CNT_EN
    check("reset.wrap", 32'(bus.wrap_count), 32'd0);
`endif
    nRST = 1'b1;

    // up wrap, R=5
    bus.rollover_val = 4'd5; bus.count_dir = 1'b1; bus.count_enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp_cnt = (i % 5) + 1;
      check_all("upwrap", exp_cnt, (exp_cnt == 5) ? 1 : 0, 0, 0);
    end

    // clear back to zero, then down wrap with R=3
    bus.count_enable = 1'b0; bus.clear = 1'b1;
    step();
    check_all("clr1", 0, 0, 0, 1);
`ifdef FLEX_COUNTER_ROLLOVER_CNT_EN
    check("clr1.wrap", 32'(bus.wrap_count), 32'd0);
`endif
    bus.clear = 1'b0; bus.rollover_val = 4'd3; bus.count_dir = 1'b0; bus.count_enable = 1'b1;
    step(); check_all("down0", 3, 1, 1, 0);
    step(); check_all("down1", 2, 0, 0, 0);
    step(); check_all("down2", 1, 0, 0, 0);
    step(); check_all("down3", 0, 0, 0, 1);
    step(); check_all("down4", 3, 1, 1, 0);
`ifdef FLEX_COUNTER_ROLLOVER_CNT_EN
    check("down.wrap", 32'(bus.wrap_count), 32'd2);
`endif

    // saturate, R=4
    bus.count_enable = 1'b0; bus.clear = 1'b1;
    step();
    bus.clear = 1'b0; bus.rollover_val = 4'd4; bus.sat_mode = 1'b1;
    bus.count_dir = 1'b1; bus.count_enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      exp_cnt = (i < 4) ? i + 1 : 4;
      check_all("satup", exp_cnt, (exp_cnt == 4) ? 1 : 0, 0, 0);
    end
    bus.count_dir = 1'b0;
    step(); check_all("satdn0", 3, 0, 0, 0);
    step(); check_all("satdn1", 2, 0, 0, 0);
    step(); check_all("satdn2", 1, 0, 0, 0);
    step(); check_all("satdn3", 0, 0, 0, 1);
    step(); check_all("satdn4", 0, 0, 1, 1);
    step(); check_all("satdn5", 0, 0, 1, 1);

    // priority: clear beats load and count
    bus.clear = 1'b1; bus.load = 1'b1; bus.load_val = 4'd9; bus.count_enable = 1'b1;
    step(); check_all("prio_clr", 0, 0, 0, 1);
    bus.clear = 1'b0; bus.count_enable = 1'b0;
    step(); check_all("prio_load", 9, 0, 0, 0);

    // out of range against R=6
    bus.load = 1'b0; bus.rollover_val = 4'd6; bus.sat_mode = 1'b0;
    bus.count_dir = 1'b1; bus.count_enable = 1'b1;
    step(); check_all("oor_upwrap", 1, 0, 0, 0);
    bus.count_enable = 1'b0; bus.load = 1'b1;
    step(); check("oor_reload1", 32'(bus.count_out), 32'd9);
    bus.load = 1'b0; bus.sat_mode = 1'b1; bus.count_enable = 1'b1;
    step(); check_all("oor_upsat", 6, 1, 0, 0);
    bus.count_enable = 1'b0; bus.load = 1'b1;
    step(); check("oor_reload2", 32'(bus.count_out), 32'd9);
    bus.load = 1'b0; bus.sat_mode = 1'b0; bus.count_dir = 1'b0; bus.count_enable = 1'b1;
    step(); check_all("oor_down", 6, 1, 0, 0);

    // R=0 disables counting
    bus.rollover_val = 4'd0; bus.count_dir = 1'b1;
    step(); check_all("r0_up", 6, 0, 0, 0);
    bus.count_dir = 1'b0;
    step(); check_all("r0_down", 6, 0, 0, 0);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    step(); check_all("r0_down_at0", 0, 0, 0, 1);

    // async reset between edges
    bus.rollover_val = 4'd5; bus.count_dir = 1'b1;
    step(); step(); step();
    check("pre_rst", 32'(bus.count_out), 32'd3);
    #3;
    nRST = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 1);
    @(posedge CLK);
    #3;
    check_all("rst_hold", 0, 0, 0, 1);
    nRST = 1'b1;
    step(); check_all("post_rst", 1, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
